rr_arbiter10: RTL and testbench

Round-robin arbiter sharing one 10-way resource among 10 requesters. It produces a registered 4-bit grant index plus a one-hot 10-bit grant vector. The index is encoded so that the downstream 4-to-10 decoder can drive the resource's select lines directly. Each grant is held until the owner signals completion, with an optional watchdog that revokes stalled grants.

---
 rtl/rr_arbiter10_defs.sv | 27 ++
 rtl/rr_pick10.sv | 29 ++
 rtl/rr_arbiter10.sv | 125 ++++++++++++
 tb/tb_rr_arbiter10.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter10_defs.sv
// Shared definitions for the 10-way round-robin arbiter: state encodings,
// the "no owner" index and modulo-10 index helpers.
package rr_arbiter10_defs;

   localparam int         N_REQ    = 10;
   localparam logic [3:0] IDX_NONE = 4'd15;
   localparam logic [3:0] IDX_LAST = 4'd9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   // Both operands are legal indices (0..9), so one conditional subtract wraps the sum.
   function automatic logic [3:0] idx_add(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= 5'(N_REQ)) sum = sum - 5'(N_REQ);
      return sum[3:0];
   endfunction

   function automatic logic [N_REQ-1:0] idx_onehot(input logic [3:0] idx);
      return (idx < 4'(N_REQ)) ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;
   endfunction

endpackage

// File: rtl/rr_pick10.sv
// Combinational rotating-priority search: first set request at or after
// i_start, wrapping 9 -> 0. o_found is low when no request is set.
module rr_pick10
   import rr_arbiter10_defs::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [3:0]       i_start,
   output logic [3:0]       o_idx,
   output logic             o_found
);

   logic [3:0] cand;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      o_idx   = IDX_NONE;
      o_found = 1'b0;
      cand    = '0;
      // Scan farthest offset first so the hit nearest to i_start overwrites the rest.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         cand = idx_add(i_start, 4'(off));
         if (i_req[cand]) begin
            o_idx   = cand;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter10.sv
// 10-requester round-robin arbiter with held grants and a dead cycle between
// owners. Optional grant watchdog enabled by defining RR_ARBITER10_TIMEOUT_EN.
module rr_arbiter10
   import rr_arbiter10_defs::*;
#(
   parameter int unsigned P_TIMEOUT = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_done,
   output logic [3:0]       o_grant_idx,
   output logic [N_REQ-1:0] o_grant,
   output logic             o_busy,
   output logic             o_timeout
);

   state_e           state_q, state_d;
   logic [3:0]       last_q, last_d;
   logic [3:0]       idx_q, idx_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic [3:0]       start_idx;
   logic [3:0]       pick_idx;
   logic             pick_found;
   logic             owner_release;
   logic             wd_fire;

   // The limit is only consumed by the watchdog, but is range-checked in every build.
   always_comb assert (P_TIMEOUT >= 1 && P_TIMEOUT <= 65535);

   assign start_idx = idx_add(last_q, 4'd1);

   rr_pick10 u_pick (
      .i_req   (i_req),
      .i_start (start_idx),
      .o_idx   (pick_idx),
      .o_found (pick_found)
   );

   assign owner_release = i_done || !i_req[idx_q];

`ifdef RR_ARBITER10_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(P_TIMEOUT);

   logic [15:0] wd_cnt_q, wd_cnt_d;

   // Held at zero outside GRANT, so it is already clear on every entry to GRANT.
   assign wd_cnt_d = (state_q == GRANT) ? wd_cnt_q + 16'd1 : '0;
   assign wd_fire  = (state_q == GRANT) && (wd_cnt_q + 16'd1 == WD_LIMIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) wd_cnt_q <= '0;
      else       wd_cnt_q <= wd_cnt_d;
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               idx_d   = pick_idx;
               busy_d  = 1'b1;
            end
         end
         GRANT: begin
            // A normal release outranks a coincident watchdog expiry.
            if (owner_release || wd_fire) begin
               state_d   = RELEASE;
               last_d    = idx_q;
               idx_d     = IDX_NONE;
               busy_d    = 1'b0;
               timeout_d = !owner_release;
            end
         end
         RELEASE: state_d = IDLE;
         default: begin
            state_d = IDLE;
            idx_d   = IDX_NONE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign grant_d = idx_onehot(idx_d);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         last_q    <= IDX_LAST;
         idx_q     <= IDX_NONE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_grant_idx = idx_q;
   assign o_grant     = grant_q;
   assign o_busy      = busy_q;
`ifdef RR_ARBITER10_TIMEOUT_EN
   assign o_timeout   = timeout_q;
`else
   assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter10.sv
// Scoreboard bench for rr_arbiter10: stimulus queues expected grants, a
// negedge monitor pops and compares each new grant and its spacing.
module tb_rr_arbiter10;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] req;
   logic       done;
   logic [3:0] grant_idx;
   logic [9:0] grant;
   logic       busy;
   logic       timeout;

   typedef struct {
      logic [3:0] idx;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_cyc = 0;
   logic busy_prev = 1'b0;

   rr_arbiter10 #(.P_TIMEOUT(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_done      (done),
      .o_grant_idx (grant_idx),
      .o_grant     (grant),
      .o_busy      (busy),
      .o_timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input logic [3:0] idx, input int gap);
      exp_t e;
      e.idx = idx;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_busy();
      int n = 0;
      while (!busy && n < 20) begin
         tick(1);
         n++;
      end
      if (!busy) begin
         total++;
         bad++;
         $display("FAIL wait_busy: got no grant within 20 cycles, required a grant");
      end
   endtask

   task automatic release_owner();
      done = 1'b1;
      tick(1);
      done = 1'b0;
      check("rel_idx", 32'(grant_idx), 32'd15);
      check("rel_grant", 32'(grant), 32'd0);
      check("rel_busy", 32'(busy), 32'd0);
      check("rel_timeout", 32'(timeout), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_idx"}, 32'(grant_idx), 32'd15);
      check({tag, "_grant"}, 32'(grant), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   // Monitor: every rising edge of o_busy is a new grant to be scored.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy && !busy_prev) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_grant: got idx %0d, required no grant", grant_idx);
            end else begin
               e = exp_q.pop_front();
               check("grant_idx", 32'(grant_idx), 32'(e.idx));
               check("grant_onehot", 32'(grant), 32'(10'd1 << e.idx));
               if (e.gap >= 0) check("grant_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
         end
         busy_prev = busy;
      end
   end

   initial begin
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      tick(2);
      check_reset_state("reset");
      rst = 1'b0;

      // Asynchronous reset while owner 3 holds the grant.
      req = 10'h008;
      expect_grant(4'd3, -1);
      wait_busy();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      req = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Full round robin: 0..9 then 0, three cycles apart.
      req = 10'h3FF;
      expect_grant(4'd0, -1);
      wait_busy();
      for (int i = 1; i <= 10; i++) begin
         release_owner();
         expect_grant(4'(i % 10), 3);
         wait_busy();
      end
      req = '0;
      release_owner();

      // Sparse requests with the pointer back at 9: 2, 9, then wrap to 2.
      rst = 1'b1;
      tick(1);
      check_reset_state("reset2");
      rst = 1'b0;
      req = 10'h204;
      expect_grant(4'd2, -1);
      wait_busy();
      release_owner();
      expect_grant(4'd9, 3);
      wait_busy();
      release_owner();
      expect_grant(4'd2, 3);
      wait_busy();
      release_owner();

      // Owner 5 drops its request without i_done.
      req = 10'h021;
      expect_grant(4'd5, 3);
      wait_busy();
      req = 10'h001;
      tick(1);
      check("drop_idx", 32'(grant_idx), 32'd15);
      check("drop_grant", 32'(grant), 32'd0);
      check("drop_busy", 32'(busy), 32'd0);
      expect_grant(4'd0, 3);
      wait_busy();

`ifdef RR_ARBITER10_TIMEOUT_EN
      release_owner();
      req = 10'h080;
      expect_grant(4'd7, 3);
      wait_busy();
      tick(3);
      check("wd_hold_busy", 32'(busy), 32'd1);
      check("wd_hold_timeout", 32'(timeout), 32'd0);
      tick(1);
      check("wd_fire_timeout", 32'(timeout), 32'd1);
      check("wd_fire_idx", 32'(grant_idx), 32'd15);
      check("wd_fire_grant", 32'(grant), 32'd0);
      req = '0;
      tick(1);
      check("wd_pulse_end", 32'(timeout), 32'd0);

      // i_done on the terminal-count cycle wins over the watchdog.
      req = 10'h080;
      expect_grant(4'd7, -1);
      wait_busy();
      tick(3);
      release_owner();
      req = '0;
      tick(1);
      check("coinc_after_timeout", 32'(timeout), 32'd0);
`else
      tick(120);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_idx", 32'(grant_idx), 32'd0);
      check("hold_grant", 32'(grant), 32'h001);
      check("hold_timeout", 32'(timeout), 32'd0);
      req = '0;
      release_owner();
`endif

      tick(3);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
